// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store over a valid/ready request
// channel, waits LATENCY cycles, then commits against an internal word RAM
// and presents the result on a valid/ready response channel.
module dmem_responder #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 16,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [WIDTH-1:0]     req_wdata,
  input  logic [WIDTH/8-1:0]   req_be,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WIDTH-1:0]     resp_rdata,
  output logic                 resp_err
);

  localparam int NB    = WIDTH / 8;
  localparam int OFF_W = (NB > 1) ? $clog2(NB) : 0;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(NB - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [3:0]        LAT_C    = 4'(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state, state_nx;

  // Latched request (held from acceptance until commit)
  logic               we_p0;
  logic [ADDR_W-1:0]  addr_p0;
  logic [WIDTH-1:0]   wdata_p0;
  logic [NB-1:0]      be_p0;
  logic [3:0]         cnt;

  logic [WIDTH-1:0]   ram [DEPTH];

  // Request as seen at the commit edge: live inputs when committing straight
  // out of IDLE (LATENCY == 0), otherwise the latched copy.
  logic               cur_we;
  logic [ADDR_W-1:0]  cur_addr;
  logic [WIDTH-1:0]   cur_wdata;
  logic [NB-1:0]      cur_be;
  logic               cur_err;
  logic [IDX_W-1:0]   cur_idx;
  logic               accept;
  logic               commit;

  // Misaligned byte address or word index beyond the RAM
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] widx;
    widx = a >> OFF_W;
    return ((a & OFF_MASK) != '0) || (widx >= DEPTH_A);
  endfunction

  // Word index into the RAM (only meaningful when addr_bad is false)
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] widx;
    widx = a >> OFF_W;
    return widx[IDX_W-1:0];
  endfunction

  // Select the request view used at the commit edge
  always_comb begin
    cur_we    = we_p0;
    cur_addr  = addr_p0;
    cur_wdata = wdata_p0;
    cur_be    = be_p0;
    if (state == S_IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end
    cur_err = addr_bad(cur_addr);
    cur_idx = word_idx(cur_addr);
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nx   = state;
    req_ready  = (state == S_IDLE) && !rst;
    resp_valid = (state == S_RESP);
    accept     = req_valid && req_ready;
    case (state)
      S_IDLE: if (accept) state_nx = (LATENCY > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (cnt <= 4'd1) state_nx = S_RESP;
      S_RESP: if (resp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    commit = !rst && (state != S_RESP) && (state_nx == S_RESP);
  end

  // State register and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      if (accept) cnt <= LAT_C;
      else if (state == S_WAIT) cnt <= cnt - 4'd1;
    end
  end

  // Request capture at acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
      be_p0    <= req_be;
    end
  end

  // ---- commit stage: response registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (commit) begin
      resp_err   <= cur_err;
      resp_rdata <= (cur_we || cur_err) ? '0 : ram[cur_idx];
    end
  end

  // RAM byte-lane writes on a committed, in-range store
  always_ff @(posedge clk) begin
    if (commit && cur_we && !cur_err) begin
      for (int i = 0; i < NB; i++) begin
        if (cur_be[i]) ram[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance at LATENCY=2 and one at
// LATENCY=4 share the request/response inputs; a select steers req_valid and
// chooses which instance's outputs are observed.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic        req_we;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_ready;

  logic        rdy2, rv2, err2, rdy4, rv4, err4;
  logic [31:0] rd2, rd4;
  logic        rdy, rv, err;
  logic [31:0] rd;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;
  exp_t sbq[$];

  dmem_responder #(.WIDTH(32), .DEPTH(256), .ADDR_W(16), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(rdy2),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(rv2), .resp_ready(resp_ready), .resp_rdata(rd2), .resp_err(err2)
  );

  dmem_responder #(.WIDTH(32), .DEPTH(256), .ADDR_W(16), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(rdy4),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(rv4), .resp_ready(resp_ready), .resp_rdata(rd4), .resp_err(err4)
  );

  assign rdy = sel ? rdy4 : rdy2;
  assign rv  = sel ? rv4  : rv2;
  assign rd  = sel ? rd4  : rd2;
  assign err = sel ? err4 : err2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One transaction: push expectation, handshake, measure latency, optional
  // backpressure, then pop and compare the response.
  task automatic xact(input logic s, input logic we, input logic [15:0] addr,
                      input logic [31:0] wd, input logic [3:0] be,
                      input logic [31:0] exp_rd, input logic exp_err, input int stall);
    int n;
    int lat;
    logic [31:0] rd_c;
    logic        err_c;
    exp_t e;
    sel = s;
    lat = s ? 4 : 2;
    e.rd = exp_rd;
    e.err = exp_err;
    sbq.push_back(e);
    req_we = we; req_addr = addr; req_wdata = wd; req_be = be; req_valid = 1'b1;
    n = 0;
    while (!rdy && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!rdy) begin
      chk_eq("accept_timeout", 32'(rdy), 32'd1);
      req_valid = 1'b0;
      void'(sbq.pop_front());
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = 16'hFFFF;
    req_wdata = $urandom;
    req_we    = ~we;
    req_be    = 4'hF;
    n = 0;
    while (!rv && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (!rv) begin
      chk_eq("resp_timeout", 32'(rv), 32'd1);
      void'(sbq.pop_front());
      return;
    end
    chk_eq("latency", 32'(n), 32'(lat));
    rd_c  = rd;
    err_c = err;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk_eq("stall_valid", 32'(rv), 32'd1);
      chk_eq("stall_rdata", rd, rd_c);
      chk_eq("stall_ready", 32'(rdy), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    e = sbq.pop_front();
    chk_eq("rdata", rd_c, e.rd);
    chk_eq("err", 32'(err_c), 32'(e.err));
    chk_eq("post_valid", 32'(rv), 32'd0);
    chk_eq("post_ready", 32'(rdy), 32'd1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0; resp_ready = 1'b0;

    // Reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk_eq("rst_ready", 32'(rdy), 32'd0);
      chk_eq("rst_valid", 32'(rv), 32'd0);
      chk_eq("rst_err", 32'(err), 32'd0);
      chk_eq("rst_rdata", rd, 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk_eq("ready_after_rst", 32'(rdy), 32'd1);

    // Store then load
    xact(0, 1, 16'h0010, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0);
    xact(0, 0, 16'h0010, 32'h0,        4'h0, 32'hDEADBEEF, 0, 0);

    // Byte enables
    xact(0, 1, 16'h0020, 32'h11223344, 4'hF, 32'h0, 0, 0);
    xact(0, 1, 16'h0020, 32'hAABBCCDD, 4'b0101, 32'h0, 0, 0);
    xact(0, 0, 16'h0020, 32'h0,        4'h0, 32'h11BB33DD, 0, 0);

    // Errors leave RAM untouched (0x0400 aliases word 0 if the range check is lost)
    xact(0, 1, 16'h0000, 32'h5A5A5A5A, 4'hF, 32'h0, 0, 0);
    xact(0, 0, 16'h0012, 32'h0,        4'h0, 32'h0, 1, 0);
    xact(0, 1, 16'h0400, 32'hFFFFFFFF, 4'hF, 32'h0, 1, 0);
    xact(0, 1, 16'h0012, 32'hFFFFFFFF, 4'hF, 32'h0, 1, 0);
    xact(0, 0, 16'h0000, 32'h0,        4'h0, 32'h5A5A5A5A, 0, 0);
    xact(0, 0, 16'h0010, 32'h0,        4'h0, 32'hDEADBEEF, 0, 0);

    // Last in-range word, and misaligned access next to it
    xact(0, 1, 16'h03FC, 32'h0BADCAFE, 4'hF, 32'h0, 0, 0);
    xact(0, 0, 16'h03FC, 32'h0,        4'h0, 32'h0BADCAFE, 0, 0);
    xact(0, 0, 16'h03FE, 32'h0,        4'h0, 32'h0, 1, 0);

    // Zero byte enables: normal ack, RAM unchanged; then load under backpressure
    xact(0, 1, 16'h0010, 32'h00000000, 4'h0, 32'h0, 0, 0);
    xact(0, 0, 16'h0010, 32'h0,        4'h0, 32'hDEADBEEF, 0, 5);

    // LATENCY=4 instance: known old value, then a store abandoned by reset
    xact(1, 1, 16'h0030, 32'hCAFEF00D, 4'hF, 32'h0, 0, 0);
    xact(1, 0, 16'h0030, 32'h0,        4'h0, 32'hCAFEF00D, 0, 0);
    sel = 1'b1;
    req_we = 1'b1; req_addr = 16'h0030; req_wdata = 32'h12345678; req_be = 4'hF;
    req_valid = 1'b1;
    seen = 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (rv) seen++;
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (rv) seen++;
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rv) seen++;
    end
    chk_eq("no_resp_after_rst", 32'(seen), 32'd0);
    chk_eq("ready_after_mid_rst", 32'(rdy), 32'd1);
    xact(1, 0, 16'h0030, 32'h0, 4'h0, 32'hCAFEF00D, 0, 0);

    chk_eq("sb_empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
